// File: rtl/risc_pkg.sv
// Shared RISC16 definitions: default geometry, word/address types, idle value.
package risc_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NREGS = 8;
  localparam int unsigned DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_WIDTH-1:0] word_t;
  typedef logic [DEF_AW-1:0]    raddr_t;

  // Value driven on a read port that is hard-wired to zero
  localparam word_t NOP = '0;

endpackage

// File: rtl/risc_rf_bypass.sv
// One register-file read port: write-back bypass priority mux plus operand-ready flag.
// Ports:
//   addr, stored, pend       - port address, stored register value and its pending bit
//   ld_done/ld_dst/ld_data   - load-return write this cycle
//   wr_en/wr_addr/wr_data    - ALU write-back this cycle
//   rd_en                    - port carries a real operand
//   data, ready, stall_req   - bypassed data, operand valid, stall contribution
module risc_rf_bypass
  import risc_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] stored,
  input  logic             pend,
  input  logic             ld_done,
  input  logic [AW-1:0]    ld_dst,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             stall_req
);

  logic is_zero;
  logic ld_hit;
  logic wr_hit;

  assign is_zero = (ZERO_R0 != 0) && (addr == '0);
  assign ld_hit  = ld_done && (ld_dst == addr);
  assign wr_hit  = wr_en && (wr_addr == addr);

  // Load return outranks ALU write-back, matching the storage write order
  always_comb begin
    data = stored;
    if (is_zero)     data = WIDTH'(NOP);
    else if (ld_hit) data = ld_data;
    else if (wr_hit) data = wr_data;
  end

  // r0 is never pending when hard-wired, so pend is already 0 there
  assign ready     = ~pend | ld_hit;
  assign stall_req = rd_en & ~ready;

endmodule

// File: rtl/risc_regfile_sb.sv
// Parametrised register file with zero-latency write-back bypass and load scoreboard.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   rd_en/rd_addr            - per-port operand enable and address (port i at [i*AW +: AW])
//   rd_data/rd_ready/stall   - bypassed read data, operand-valid, stall request (combinational)
//   wr_en/wr_addr/wr_data    - ALU write-back port
//   ld_issue/ld_addr         - load issue, marks destination pending
//   ld_done/ld_dst/ld_data   - load return, writes and clears pending
//   flush                    - cancel all outstanding loads
//   pending, err             - registered pending vector, sticky protocol error
module risc_regfile_sb
  import risc_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NREGS   = DEF_NREGS,
  parameter int unsigned NRD     = 2,
  parameter int unsigned ZERO_R0 = 0,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_ready,
  output logic                 stall,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 ld_issue,
  input  logic [AW-1:0]        ld_addr,
  input  logic                 ld_done,
  input  logic [AW-1:0]        ld_dst,
  input  logic [WIDTH-1:0]     ld_data,
  input  logic                 flush,
  output logic [NREGS-1:0]     pending,
  output logic                 err
);

  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_ok;
  logic             ld_ok;
  logic             iss_ok;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;
  logic [NREGS-1:0] pending_nxt;
  logic             err_set;
  logic [NRD-1:0]   stall_req;

  // Accesses to a hard-wired r0 are dropped silently
  assign wr_ok  = wr_en    && !((ZERO_R0 != 0) && (wr_addr == '0));
  assign ld_ok  = ld_done  && !((ZERO_R0 != 0) && (ld_dst  == '0));
  assign iss_ok = ld_issue && !((ZERO_R0 != 0) && (ld_addr == '0));

  // Scoreboard next state and protocol-error detection
  always_comb begin
    set_v       = '0;
    clr_v       = '0;
    err_set     = 1'b0;
    if (iss_ok) set_v = NREGS'(1) << ld_addr;
    if (ld_ok)  clr_v = NREGS'(1) << ld_dst;
    pending_nxt = flush ? set_v : ((pending & ~clr_v) | set_v);
    if (iss_ok && pending[ld_addr] && !(ld_ok && (ld_dst == ld_addr))) err_set = 1'b1;
    if (wr_ok && pending[wr_addr])                                      err_set = 1'b1;
    if (ld_ok && !pending[ld_dst])                                      err_set = 1'b1;
    if (wr_ok && ld_ok && (wr_addr == ld_dst))                          err_set = 1'b1;
  end

  // Storage, pending vector and sticky error; load return is written last so it wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(NREGS); r++) regs[r] <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      if (ld_ok) regs[ld_dst]  <= ld_data;
      pending <= pending_nxt;
      if (err_set) err <= 1'b1;
    end
  end

  // Read ports
  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[i*AW +: AW];

    risc_rf_bypass #(
      .WIDTH   (WIDTH),
      .AW      (AW),
      .ZERO_R0 (ZERO_R0)
    ) u_port (
      .addr      (a),
      .stored    (regs[a]),
      .pend      (pending[a]),
      .ld_done   (ld_ok),
      .ld_dst    (ld_dst),
      .ld_data   (ld_data),
      .wr_en     (wr_ok),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en[i]),
      .data      (rd_data[i*WIDTH +: WIDTH]),
      .ready     (rd_ready[i]),
      .stall_req (stall_req[i])
    );
  end

  assign stall = |stall_req;

endmodule

// File: tb/tb_risc_regfile_sb.sv
module tb_risc_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance: 16-bit, 8 regs, 2 ports, r0 writable
  logic [1:0]  a_rd_en;
  logic [5:0]  a_rd_addr;
  logic [31:0] a_rd_data;
  logic [1:0]  a_rd_ready;
  logic        a_stall;
  logic        a_wr_en, a_ld_issue, a_ld_done, a_flush;
  logic [2:0]  a_wr_addr, a_ld_addr, a_ld_dst;
  logic [15:0] a_wr_data, a_ld_data;
  logic [7:0]  a_pending;
  logic        a_err;

  risc_regfile_sb u_a (
    .clk(clk), .rst(rst),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_ready(a_rd_ready), .stall(a_stall),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .ld_issue(a_ld_issue), .ld_addr(a_ld_addr),
    .ld_done(a_ld_done), .ld_dst(a_ld_dst), .ld_data(a_ld_data),
    .flush(a_flush), .pending(a_pending), .err(a_err)
  );

  // Wide instance: 32-bit, 16 regs, 3 ports, r0 hard-wired
  logic [2:0]  b_rd_en;
  logic [11:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_ready;
  logic        b_stall;
  logic        b_wr_en, b_ld_issue, b_ld_done, b_flush;
  logic [3:0]  b_wr_addr, b_ld_addr, b_ld_dst;
  logic [31:0] b_wr_data, b_ld_data;
  logic [15:0] b_pending;
  logic        b_err;

  risc_regfile_sb #(.WIDTH(32), .NREGS(16), .NRD(3), .ZERO_R0(1)) u_b (
    .clk(clk), .rst(rst),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_ready(b_rd_ready), .stall(b_stall),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .ld_issue(b_ld_issue), .ld_addr(b_ld_addr),
    .ld_done(b_ld_done), .ld_dst(b_ld_dst), .ld_data(b_ld_data),
    .flush(b_flush), .pending(b_pending), .err(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle inputs away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_wr_en = 0; a_ld_issue = 0; a_ld_done = 0; a_flush = 0;
  endtask

  initial begin
    a_rd_en = 2'b11; a_rd_addr = {3'd3, 3'd0};
    a_wr_addr = 0; a_wr_data = 0; a_ld_addr = 0; a_ld_dst = 0; a_ld_data = 0;
    idle_a();
    b_rd_en = 0; b_rd_addr = 0; b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0;
    b_ld_issue = 0; b_ld_addr = 0; b_ld_done = 0; b_ld_dst = 0; b_ld_data = 0;
    b_flush = 0;

    // 1. reset state
    #2;
    chk("rst_data",    64'(a_rd_data),  64'h0);
    chk("rst_ready",   64'(a_rd_ready), 64'h3);
    chk("rst_stall",   64'(a_stall),    64'h0);
    chk("rst_pending", 64'(a_pending),  64'h0);
    chk("rst_err",     64'(a_err),      64'h0);
    step();
    rst = 0;
    step();

    // 2. same-cycle bypass then stored value
    a_rd_en = 2'b00; a_rd_addr = {3'd0, 3'd3};
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 16'h1234;
    #1 chk("wr_bypass", 64'(a_rd_data[15:0]), 64'h1234);
    step();
    a_wr_en = 0;
    #1 chk("wr_stored", 64'(a_rd_data[15:0]), 64'h1234);

    // 3. load scoreboard stall and release
    a_ld_issue = 1; a_ld_addr = 5;
    step();
    a_ld_issue = 0; a_rd_en = 2'b01; a_rd_addr = {3'd0, 3'd5};
    #1;
    chk("ld_stall",   64'(a_stall),    64'h1);
    chk("ld_pending", 64'(a_pending),  64'h20);
    chk("ld_ready0",  64'(a_rd_ready[0]), 64'h0);
    a_ld_done = 1; a_ld_dst = 5; a_ld_data = 16'hBEEF;
    #1;
    chk("ld_ret_data",  64'(a_rd_data[15:0]), 64'hBEEF);
    chk("ld_ret_stall", 64'(a_stall),         64'h0);
    step();
    a_ld_done = 0; a_rd_en = 2'b00;
    #1;
    chk("ld_clr_pending", 64'(a_pending), 64'h0);
    chk("ld_clean_err",   64'(a_err),     64'h0);

    // 4. wr/ld collision: load data wins, err sticky
    a_ld_done = 1; a_ld_dst = 2; a_ld_data = 16'hAAAA;
    a_wr_en = 1; a_wr_addr = 2; a_wr_data = 16'h5555;
    step();
    idle_a(); a_rd_addr = {3'd0, 3'd2};
    #1;
    chk("coll_data", 64'(a_rd_data[15:0]), 64'hAAAA);
    chk("coll_err",  64'(a_err),           64'h1);
    step(); step(); step();
    chk("err_sticky", 64'(a_err), 64'h1);

    rst = 1;
    #1 chk("rst_clears_err", 64'(a_err), 64'h0);
    step();
    rst = 0;
    step();

    // 5. flush keeps a same-cycle issue; late return is an error but writes
    a_ld_issue = 1; a_ld_addr = 1;
    step();
    a_flush = 1; a_ld_addr = 4;
    step();
    idle_a();
    #1;
    chk("flush_pending", 64'(a_pending), 64'h10);
    chk("flush_err",     64'(a_err),     64'h0);
    a_ld_done = 1; a_ld_dst = 1; a_ld_data = 16'h7777;
    step();
    idle_a(); a_rd_addr = {3'd0, 3'd1};
    #1;
    chk("late_err",     64'(a_err),            64'h1);
    chk("late_data",    64'(a_rd_data[15:0]),  64'h7777);
    chk("late_pending", 64'(a_pending),        64'h10);

    // issue + done on the same pending register: written, stays pending
    a_ld_issue = 1; a_ld_addr = 4; a_ld_done = 1; a_ld_dst = 4; a_ld_data = 16'h4444;
    step();
    idle_a(); a_rd_addr = {3'd0, 3'd4};
    #1;
    chk("reiss_pending", 64'(a_pending),          64'h10);
    chk("reiss_data",    64'(a_rd_data[15:0]),    64'h4444);
    chk("reiss_ready",   64'(a_rd_ready[0]),      64'h0);

    // 6. ZERO_R0 wide instance
    b_wr_en = 1; b_wr_addr = 0; b_wr_data = 32'hFFFF_FFFF; b_rd_addr = 12'h000;
    #1 chk("r0_bypass", 64'(b_rd_data[31:0]), 64'h0);
    step();
    b_wr_en = 0;
    #1 chk("r0_stored", 64'(b_rd_data[31:0]), 64'h0);
    b_ld_issue = 1; b_ld_addr = 0;
    step();
    b_ld_issue = 0;
    #1;
    chk("r0_pending", 64'(b_pending), 64'h0);
    chk("r0_err",     64'(b_err),     64'h0);
    b_wr_en = 1; b_wr_addr = 15; b_wr_data = 32'hDEAD_BEEF;
    step();
    b_wr_en = 0; b_rd_en = 3'b111; b_rd_addr = {4'd15, 4'd15, 4'd15};
    #1;
    chk("r15_p0", 64'(b_rd_data[31:0]),  64'hDEAD_BEEF);
    chk("r15_p1", 64'(b_rd_data[63:32]), 64'hDEAD_BEEF);
    chk("r15_p2", 64'(b_rd_data[95:64]), 64'hDEAD_BEEF);
    chk("r15_stall", 64'(b_stall),       64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
